// File: rtl/logic_axi4_stream_mux_arbiter_stage.sv
// logic_axi4_stream_mux_arbiter_stage: RADIX:1 round-robin AXI4-Stream mux stage with packet lock and 2-entry output skid
module logic_axi4_stream_mux_arbiter_stage #(
  parameter int INPUTS = 2,
  parameter int RADIX = 2,
  parameter int OUTPUTS = (INPUTS + RADIX - 1) / RADIX,
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH = 1,
  parameter bit USE_TLAST = 1,
  parameter bit USE_TKEEP = 1,
  parameter bit USE_TSTRB = 1,
  parameter bit PACKET_LOCK = 1,
  localparam int GW = $clog2(RADIX),
  localparam int DW = 8 * TDATA_BYTES
) (
  input  logic aclk,
  input  logic areset,
  input  logic [INPUTS-1:0] rx_tvalid,
  output logic [INPUTS-1:0] rx_tready,
  input  logic [INPUTS-1:0][DW-1:0] rx_tdata,
  input  logic [INPUTS-1:0][TDATA_BYTES-1:0] rx_tkeep,
  input  logic [INPUTS-1:0][TDATA_BYTES-1:0] rx_tstrb,
  input  logic [INPUTS-1:0] rx_tlast,
  input  logic [INPUTS-1:0][TID_WIDTH-1:0] rx_tid,
  input  logic [INPUTS-1:0][TDEST_WIDTH-1:0] rx_tdest,
  input  logic [INPUTS-1:0][TUSER_WIDTH-1:0] rx_tuser,
  output logic [OUTPUTS-1:0] tx_tvalid,
  input  logic [OUTPUTS-1:0] tx_tready,
  output logic [OUTPUTS-1:0][DW-1:0] tx_tdata,
  output logic [OUTPUTS-1:0][TDATA_BYTES-1:0] tx_tkeep,
  output logic [OUTPUTS-1:0][TDATA_BYTES-1:0] tx_tstrb,
  output logic [OUTPUTS-1:0] tx_tlast,
  output logic [OUTPUTS-1:0][TID_WIDTH-1:0] tx_tid,
  output logic [OUTPUTS-1:0][TDEST_WIDTH-1:0] tx_tdest,
  output logic [OUTPUTS-1:0][TUSER_WIDTH-1:0] tx_tuser,
  output logic [OUTPUTS-1:0][GW-1:0] grant
);
  localparam int KW = TDATA_BYTES;
  localparam int TL = DW + 2 * KW;
  localparam int BW = TL + 1 + TUSER_WIDTH + TDEST_WIDTH + TID_WIDTH;
  logic [BW-1:0] beat [INPUTS];
  for (genvar i = 0; i < INPUTS; i++) begin : g_pack
    assign beat[i] = {rx_tid[i], rx_tdest[i], rx_tuser[i], USE_TLAST ? rx_tlast[i] : 1'b1,
                      rx_tkeep[i], rx_tstrb[i], rx_tdata[i]};
  end
  for (genvar g = 0; g < OUTPUTS; g++) begin : g_grp
    localparam int BASE = g * RADIX;
    localparam int M = (INPUTS - BASE < RADIX) ? INPUTS - BASE : RADIX;
    logic [RADIX-1:0] gv;
    logic [BW-1:0] gb [RADIX];
    logic [M-1:0] gr;
    logic [GW-1:0] ptr, ptr_n, sel;
    logic locked, locked_n, hit, push, pop;
    logic [1:0] cnt;
    logic [BW-1:0] b0, b1;
    int j;
    for (genvar i = 0; i < RADIX; i++) begin : g_in
      if (i < M) begin : g_used
        assign gv[i] = rx_tvalid[BASE+i];
        assign gb[i] = beat[BASE+i];
        assign rx_tready[BASE+i] = gr[i];
      end else begin : g_pad
        assign gv[i] = 1'b0;
        assign gb[i] = '0;
      end
    end
    assign push = hit & ~cnt[1] & ~areset;
    assign pop = (cnt != 2'd0) & tx_tready[g];
    // arbitration state: pointer/grant and packet lock, plus skid occupancy
    always_ff @(posedge aclk) begin
      if (areset) begin
        ptr <= '0;
        locked <= 1'b0;
        cnt <= 2'd0;
      end else begin
        ptr <= ptr_n;
        locked <= locked_n;
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
    end
    // round-robin search starting after ptr; a lock pins selection to ptr
    always_comb begin
      sel = ptr;
      hit = 1'b0;
      j = 0;
      for (int k = M; k >= 1; k--) begin
        j = int'(ptr) + k;
        j = j >= M ? j - M : j;
        if (gv[GW'(j)]) begin
          sel = GW'(j);
          hit = 1'b1;
        end
      end
      if (locked) begin
        sel = ptr;
        hit = gv[ptr];
      end
      ptr_n = push ? sel : ptr;
      locked_n = push ? (PACKET_LOCK && !gb[sel][TL]) : locked;
    end
    // only the selected input sees tready, and only while the skid has room
    always_comb begin
      gr = '0;
      for (int k = 0; k < M; k++) gr[k] = (int'(sel) == k) && !cnt[1] && !areset;
    end
    // skid storage: b0 is the head presented on tx, b1 catches the beat that arrives while stalled
    always_ff @(posedge aclk) begin
      b0 <= (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) ? gb[sel] : (pop && cnt[1]) ? b1 : b0;
      b1 <= (push && cnt == 2'd1 && !pop) ? gb[sel] : b1;
    end
    assign tx_tvalid[g] = cnt != 2'd0;
    assign tx_tdata[g] = b0[DW-1:0];
    assign tx_tstrb[g] = USE_TSTRB ? b0[DW +: KW] : '1;
    assign tx_tkeep[g] = USE_TKEEP ? b0[DW+KW +: KW] : '1;
    assign tx_tlast[g] = USE_TLAST ? b0[TL] : 1'b1;
    assign tx_tuser[g] = b0[TL+1 +: TUSER_WIDTH];
    assign tx_tdest[g] = b0[TL+1+TUSER_WIDTH +: TDEST_WIDTH];
    assign tx_tid[g] = b0[TL+1+TUSER_WIDTH+TDEST_WIDTH +: TID_WIDTH];
    assign grant[g] = ptr;
  end
endmodule
